// File: rtl/tx_fsk_mod.sv
// tx_fsk_mod: serial TX bitstream to DCO frequency control word.
// Slew-limited FSK about a channel centre, PA sequenced per packet.
module tx_fsk_mod #(
  parameter int FCW_W    = 16,
  parameter int CH_IDX_W = 6,
  parameter int SPB      = 16,
  parameter int DEV      = 250,
  parameter int STEP     = 50,
  parameter int HOLD     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [FCW_W-1:0]    base_fcw,
  input  logic [FCW_W-1:0]    ch_step,
  input  logic [CH_IDX_W-1:0] ch_idx,
  input  logic                tx,
  input  logic                tx_valid,
  output logic [FCW_W-1:0]    fcw,
  output logic                fcw_valid,
  output logic                pa_en,
  output logic                busy,
  output logic                restart_err
);
  localparam int BCW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int HCW = $clog2(HOLD + 1);
  localparam logic [FCW_W-1:0] DEV_W = FCW_W'(DEV);
  localparam logic [FCW_W-1:0] STEP_W = FCW_W'(STEP);
  localparam logic signed [FCW_W-1:0] STEP_S = FCW_W'(STEP);
  localparam logic [BCW-1:0] BC_LAST = BCW'(SPB - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, MOD, DRAIN} state_t;

  state_t state, state_nxt;
  logic tv_d, rise, at_centre;
  logic tx_bit, bit_nxt;
  logic act_nxt, err_nxt;
  logic [BCW-1:0] bcnt, bcnt_nxt;
  logic [HCW-1:0] hcnt, hcnt_nxt;
  logic [FCW_W-1:0] centre, centre_nxt, centre_calc;
  logic [FCW_W-1:0] chan_off, fcw_nxt;
  logic [FCW_W-1:0] target, ramp;
  logic signed [FCW_W-1:0] diff;

  assign rise = tx_valid & ~tv_d;
  assign at_centre = (fcw == centre);
  assign chan_off = ch_step * FCW_W'(ch_idx);
  assign centre_calc = base_fcw + chan_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tv_d        <= 1'b0;
      tx_bit      <= 1'b0;
      bcnt        <= '0;
      hcnt        <= '0;
      centre      <= '0;
      fcw         <= '0;
      fcw_valid   <= 1'b0;
      pa_en       <= 1'b0;
      busy        <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tv_d        <= tx_valid;
      tx_bit      <= bit_nxt;
      bcnt        <= bcnt_nxt;
      hcnt        <= hcnt_nxt;
      centre      <= centre_nxt;
      fcw         <= fcw_nxt;
      fcw_valid   <= act_nxt;
      pa_en       <= act_nxt;
      busy        <= act_nxt;
      restart_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (rise) state_nxt = MOD;
        MOD:   if (!tx_valid) state_nxt = DRAIN;
        DRAIN: if (at_centre && hcnt == HC_LAST)
                 state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    target = centre;
    if (state == MOD)
      target = tx_bit ? centre + DEV_W : centre - DEV_W;
    // signed modulo distance keeps the ramp short across FCW wrap
    diff = target - fcw;
    if (diff > STEP_S)       ramp = fcw + STEP_W;
    else if (diff < -STEP_S) ramp = fcw - STEP_W;
    else                     ramp = target;

    centre_nxt = centre;
    bit_nxt    = tx_bit;
    bcnt_nxt   = bcnt;
    hcnt_nxt   = hcnt;
    fcw_nxt    = fcw;
    act_nxt    = (state_nxt != IDLE);
    err_nxt    = en & rise & (state != IDLE);

    if (!act_nxt) begin
      fcw_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          centre_nxt = centre_calc;
          fcw_nxt    = centre_calc;
          bit_nxt    = tx;
          bcnt_nxt   = BCW'(1);
          hcnt_nxt   = '0;
        end
        MOD: begin
          fcw_nxt  = ramp;
          hcnt_nxt = '0;
          if (bcnt == '0) bit_nxt = tx;
          bcnt_nxt = (bcnt == BC_LAST) ? '0
                                       : bcnt + BCW'(1);
        end
        DRAIN: begin
          if (at_centre) begin
            hcnt_nxt = hcnt + HCW'(1);
          end else begin
            fcw_nxt  = ramp;
            hcnt_nxt = '0;
          end
        end
        default: fcw_nxt = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_fsk_mod.sv
// tb_tx_fsk_mod: scenario tasks plus random packets checked
// against an offset-based behavioural model of the FSK modulator.
module tb_tx_fsk_mod;
  localparam int FCW_W = 16;
  localparam int CH_IDX_W = 6;
  localparam int SPB = 16;
  localparam int DEV = 250;
  localparam int STEP = 50;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic tx = 1'b0;
  logic tx_valid = 1'b0;
  logic [FCW_W-1:0] base_fcw = '0;
  logic [FCW_W-1:0] ch_step = '0;
  logic [CH_IDX_W-1:0] ch_idx = '0;
  logic [FCW_W-1:0] fcw;
  logic fcw_valid, pa_en, busy, restart_err;
  logic [19:0] dut_out;

  int n_cmp = 0;
  int n_bad = 0;

  tx_fsk_mod #(
    .FCW_W(FCW_W), .CH_IDX_W(CH_IDX_W), .SPB(SPB),
    .DEV(DEV), .STEP(STEP), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .base_fcw(base_fcw), .ch_step(ch_step), .ch_idx(ch_idx),
    .tx(tx), .tx_valid(tx_valid),
    .fcw(fcw), .fcw_valid(fcw_valid), .pa_en(pa_en),
    .busy(busy), .restart_err(restart_err)
  );

  assign dut_out = {fcw, fcw_valid, pa_en, busy, restart_err};

  always #5 clk = ~clk;

  // model: packet phase, integer offset from centre, bit age
  int m_mode, m_off, m_bit, m_age, m_hold;
  int unsigned m_centre;
  bit m_tv, m_rise, m_err;

  function automatic int approach(int cur, int goal);
    if (goal > cur) return (goal - cur > STEP) ? cur + STEP : goal;
    return (cur - goal > STEP) ? cur - STEP : goal;
  endfunction

  function automatic logic [19:0] exp_out();
    logic [31:0] s;
    s = 32'(m_centre) + 32'(m_off);
    if (m_mode == 0) return {16'h0, 3'b000, m_err};
    return {s[15:0], 3'b111, m_err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_off = 0; m_bit = 0; m_age = 0; m_hold = 0;
      m_centre = 0; m_tv = 0; m_err = 0;
    end else begin
      m_rise = tx_valid && !m_tv;
      m_err = en && m_rise && (m_mode != 0);
      if (!en) m_mode = 0;
      else case (m_mode)
        0: if (m_rise) begin
          m_centre = (int'(base_fcw) + int'(ch_idx) * int'(ch_step)) % 65536;
          m_off = 0; m_bit = int'(tx); m_age = 1; m_mode = 1;
        end
        1: begin
          m_off = approach(m_off, (m_bit != 0) ? DEV : -DEV);
          if (m_age % SPB == 0) m_bit = int'(tx);
          m_age++;
          if (!tx_valid) begin m_mode = 2; m_hold = 0; end
        end
        default: begin
          if (m_off != 0) m_off = approach(m_off, 0);
          else if (m_hold == HOLD - 1) m_mode = 0;
          else m_hold++;
        end
      endcase
      m_tv = tx_valid;
    end
  end

  task automatic test_reset();
    rst_n = 0; en = 0; tx_valid = 0; tx = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_out !== 20'h0) begin
      n_bad++; $display("FAIL reset: got %h want %h", dut_out, 20'h0);
    end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (dut_out !== exp_out()) begin
      n_bad++; $display("FAIL reset_rel: got %h want %h", dut_out, exp_out());
    end
  endtask

  task automatic test_swing();
    int ck_cyc[7] = '{1, 6, 7, 17, 18, 27, 33};
    logic [15:0] ck_val[7] = '{16'h4500, 16'h45FA, 16'h45FA, 16'h45FA,
                               16'h45C8, 16'h4406, 16'h4406};
    int hold_cnt;
    en = 1; base_fcw = 16'h4000; ch_step = 16'h0100; ch_idx = 6'd5;
    tx = 1; tx_valid = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL swing c%0d: got %h want %h", i, dut_out, exp_out());
      end
      for (int k = 0; k < 7; k++) begin
        if (i == ck_cyc[k]) begin
          n_cmp++;
          if (fcw !== ck_val[k]) begin
            n_bad++; $display("FAIL swing_pt c%0d: got %h want %h", i, fcw, ck_val[k]);
          end
        end
      end
      if (i == 1) begin base_fcw = 16'($urandom); ch_idx = 6'($urandom); end
      if (i == 8) tx = 0;
      if (i == 24) tx = 1;
      if (i == 40) tx_valid = 0;
    end
    hold_cnt = 0;
    for (int j = 0; j < 60 && busy; j++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL drain c%0d: got %h want %h", j, dut_out, exp_out());
      end
      if (pa_en && fcw == 16'h4500) hold_cnt++;
    end
    n_cmp++;
    if (hold_cnt != HOLD || busy !== 1'b0 || fcw !== 16'h0) begin
      n_bad++;
      $display("FAIL drain_hold: got hold=%0d busy=%b fcw=%h want hold=%0d busy=0 fcw=0",
               hold_cnt, busy, fcw, HOLD);
    end
  endtask

  task automatic test_wrap();
    en = 1; base_fcw = 16'hFF00; ch_step = 16'h0100; ch_idx = 6'd1;
    tx = 0; tx_valid = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL wrap c%0d: got %h want %h", i, dut_out, exp_out());
      end
      n_cmp++;
      if (fcw > 16'h0000 && fcw < 16'h8000) begin
        n_bad++; $display("FAIL wrap_glitch c%0d: got %h want 0 or >=8000", i, fcw);
      end
      if (i == 6) begin
        n_cmp++;
        if (fcw !== 16'hFF06) begin
          n_bad++; $display("FAIL wrap_pt: got %h want %h", fcw, 16'hFF06);
        end
      end
    end
    tx_valid = 0;
    for (int j = 0; j < 60 && busy; j++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL wrap_drain c%0d: got %h want %h", j, dut_out, exp_out());
      end
    end
  endtask

  task automatic test_restart();
    int pulses;
    en = 1; base_fcw = 16'($urandom); ch_step = 16'($urandom);
    ch_idx = 6'($urandom); tx = 1'($urandom); tx_valid = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL restart_mod c%0d: got %h want %h", i, dut_out, exp_out());
      end
      tx = 1'($urandom);
    end
    tx_valid = 0;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++; $display("FAIL restart_drain c%0d: got %h want %h", i, dut_out, exp_out());
      end
      if (restart_err) pulses++;
      if (i == 1) tx_valid = 1;
    end
    n_cmp++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL restart_pulse: got pulses=%0d busy=%b want 1 and 0", pulses, busy);
    end
    tx_valid = 0;
    @(negedge clk);
    tx_valid = 1;
    @(negedge clk);
    n_cmp++;
    if ({fcw_valid, pa_en, busy} !== 3'b111 || dut_out !== exp_out()) begin
      n_bad++; $display("FAIL restart_new: got %h want %h", dut_out, exp_out());
    end
    tx_valid = 0;
    for (int j = 0; j < 60 && busy; j++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL restart_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    en = 1; base_fcw = 16'($urandom); ch_step = 16'($urandom);
    ch_idx = 6'($urandom); tx = 1; tx_valid = 1;
    repeat (10) @(negedge clk);
    en = 0;
    @(negedge clk);
    n_cmp++;
    if (dut_out !== 20'h0) begin
      n_bad++; $display("FAIL abort_en: got %h want %h", dut_out, 20'h0);
    end
    en = 1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out !== exp_out() || busy !== 1'b0) begin
        n_bad++; $display("FAIL abort_norestart: got %h want %h", dut_out, exp_out());
      end
    end
    tx_valid = 0;
    @(negedge clk);
    tx_valid = 1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || dut_out !== exp_out()) begin
      n_bad++; $display("FAIL abort_new: got %h want %h", dut_out, exp_out());
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (dut_out !== 20'h0) begin
      n_bad++; $display("FAIL abort_rst: got %h want %h", dut_out, 20'h0);
    end
    @(negedge clk);
    rst_n = 1; tx_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dut_out !== exp_out()) begin
      n_bad++; $display("FAIL abort_rel: got %h want %h", dut_out, exp_out());
    end
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 8; p++) begin
      len = int'($urandom_range(20, 90));
      en = 1; tx_valid = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_out !== exp_out()) begin
          n_bad++; $display("FAIL rand_idle p%0d: got %h want %h", p, dut_out, exp_out());
        end
      end
      base_fcw = 16'($urandom); ch_step = 16'($urandom);
      ch_idx = 6'($urandom); tx = 1'($urandom); tx_valid = 1;
      for (int i = 0; i < len + 30; i++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_out !== exp_out()) begin
          n_bad++; $display("FAIL rand p%0d c%0d: got %h want %h", p, i, dut_out, exp_out());
        end
        tx = 1'($urandom);
        if ($urandom_range(0, 15) == 0) base_fcw = 16'($urandom);
        if ($urandom_range(0, 15) == 0) ch_idx = 6'($urandom);
        en = ($urandom_range(0, 99) != 0);
        if (i >= len) tx_valid = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_swing();
    test_wrap();
    test_restart();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
